// File: rtl/circle_pkg.sv
// Shared constants and state encoding for the midpoint-circle rasteriser.
// Optional clipping build: define CIRCLE_CLIP_EN.
package circle_pkg;

  localparam int CW   = 10;
  localparam int DW   = 12;
  localparam int NOCT = 8;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    STEP,
    DONE
  } state_t;

endpackage

// File: rtl/circle_octant_sel.sv
// Mirrors the current octant-0 offset into one of eight octants.
// With CIRCLE_CLIP_EN, flags candidates outside the visible area.
module circle_octant_sel
  import circle_pkg::*;
#(
  parameter int XC   = 320,
  parameter int YC   = 240,
  parameter int XMAX = 640,
  parameter int YMAX = 480
) (
  input  logic [CW-1:0] ox,
  input  logic [CW-1:0] oy,
  input  logic [2:0]    oct,
  output logic [CW-1:0] cx,
  output logic [CW-1:0] cy,
  output logic          in_range
);

  localparam logic [CW-1:0] XC_W = CW'(XC);
  localparam logic [CW-1:0] YC_W = CW'(YC);

  logic [CW-1:0] a;
  logic [CW-1:0] b;

  // Octants 4..7 swap the roles of ox and oy.
  assign a  = oct[2] ? oy : ox;
  assign b  = oct[2] ? ox : oy;
  assign cx = oct[0] ? XC_W - a : XC_W + a;
  assign cy = oct[1] ? YC_W - b : YC_W + b;

`ifdef CIRCLE_CLIP_EN
  localparam logic signed [CW:0] XMAX_S = (CW+1)'(XMAX);
  localparam logic signed [CW:0] YMAX_S = (CW+1)'(YMAX);

  logic signed [CW:0] sx;
  logic signed [CW:0] sy;

  assign sx = oct[0]
    ? $signed({1'b0, XC_W}) - $signed({1'b0, a})
    : $signed({1'b0, XC_W}) + $signed({1'b0, a});
  assign sy = oct[1]
    ? $signed({1'b0, YC_W}) - $signed({1'b0, b})
    : $signed({1'b0, YC_W}) + $signed({1'b0, b});

  assign in_range = (sx >= 0) && (sx < XMAX_S)
                 && (sy >= 0) && (sy < YMAX_S);
`else
  localparam logic VIS = (XMAX > 0) && (YMAX > 0);

  assign in_range = 1'b1 | VIS;
`endif

endmodule

// File: rtl/circle_point_gen.sv
// Midpoint-circle outline generator streaming 8-way mirrored points.
// Optional clipping build: define CIRCLE_CLIP_EN.
module circle_point_gen
  import circle_pkg::*;
#(
  parameter int XC   = 320,
  parameter int YC   = 240,
  parameter int R    = 100,
  parameter int XMAX = 640,
  parameter int YMAX = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0]        R_W = CW'(R);
  localparam logic signed [DW-1:0] D0  = DW'(1 - R);

  state_t               state, state_n;
  logic [CW-1:0]        ox, ox_n;
  logic [CW-1:0]        oy, oy_n;
  logic signed [DW-1:0] d, d_n;
  logic [2:0]           oct, oct_n;

  logic [CW-1:0]        cx;
  logic [CW-1:0]        cy;
  logic                 in_range;
  logic signed [DW-1:0] oy_e;
  logic signed [DW-1:0] ox_e;
  logic                 go_on;

  circle_octant_sel #(
    .XC   (XC),
    .YC   (YC),
    .XMAX (XMAX),
    .YMAX (YMAX)
  ) u_sel (
    .ox       (ox),
    .oy       (oy),
    .oct      (oct),
    .cx       (cx),
    .cy       (cy),
    .in_range (in_range)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ox    <= '0;
      oy    <= '0;
      d     <= '0;
      oct   <= '0;
    end else begin
      state <= state_n;
      ox    <= ox_n;
      oy    <= oy_n;
      d     <= d_n;
      oct   <= oct_n;
    end
  end

  always_comb begin
    state_n = state;
    ox_n    = ox;
    oy_n    = oy;
    d_n     = d;
    oct_n   = oct;
    valid   = 1'b0;
    done    = 1'b0;
    go_on   = 1'b0;
    busy    = (state != IDLE);
    // Signed views keep ox=0 from wrapping when it steps below zero.
    oy_e    = $signed({2'b00, oy}) + DW'(1);
    ox_e    = $signed({2'b00, ox}) - DW'(1);
    unique case (state)
      IDLE: begin
        if (start) begin
          ox_n    = R_W;
          oy_n    = '0;
          d_n     = D0;
          oct_n   = '0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        valid = in_range;
        if (!in_range || ready) begin
          if (oct == 3'(NOCT - 1)) state_n = STEP;
          else oct_n = oct + 3'd1;
        end
      end
      STEP: begin
        oy_n  = oy + CW'(1);
        oct_n = '0;
        if (d[DW-1]) begin
          d_n   = d + (oy_e <<< 1) + DW'(1);
          go_on = oy_e <= $signed({2'b00, ox});
        end else begin
          ox_n  = ox - CW'(1);
          d_n   = d + ((oy_e - ox_e) <<< 1) + DW'(1);
          go_on = oy_e <= ox_e;
        end
        state_n = go_on ? EMIT : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign x = valid ? cx : '0;
  assign y = valid ? cy : '0;

endmodule

// File: tb/tb_circle_point_gen.sv
// Randomised-handshake bench for circle_point_gen against a plain
// integer midpoint-circle model; honours CIRCLE_CLIP_EN.
module tb_circle_point_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s [3];
  logic       ready_s [3];
  logic [9:0] xs      [3];
  logic [9:0] ys      [3];
  logic       valid_s [3];
  logic       busy_s  [3];
  logic       done_s  [3];

  int vectors = 0;
  int errors  = 0;

  int XCS [3] = '{10, 320, 2};
  int YCS [3] = '{10, 240, 10};
  int RS  [3] = '{5, 1, 5};

  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  circle_point_gen #(.XC(10), .YC(10), .R(5)) u0 (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .x(xs[0]), .y(ys[0]), .valid(valid_s[0]),
    .ready(ready_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  circle_point_gen #(.XC(320), .YC(240), .R(1)) u1 (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .x(xs[1]), .y(ys[1]), .valid(valid_s[1]),
    .ready(ready_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  circle_point_gen #(.XC(2), .YC(10), .R(5)) u2 (
    .clk(clk), .reset(reset), .start(start_s[2]),
    .x(xs[2]), .y(ys[2]), .valid(valid_s[2]),
    .ready(ready_s[2]), .busy(busy_s[2]), .done(done_s[2])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook midpoint circle, mirrored 8 ways.
  task automatic build(input int i);
    int px, py, a, b, cxo, cyo, dd;
    exp_q.delete();
    cxo = RS[i];
    cyo = 0;
    dd  = 1 - RS[i];
    do begin
      for (int k = 0; k < 8; k++) begin
        a  = (k < 4) ? cxo : cyo;
        b  = (k < 4) ? cyo : cxo;
        px = XCS[i] + (((k & 1) != 0) ? -a : a);
        py = YCS[i] + (((k & 2) != 0) ? -b : b);
`ifdef CIRCLE_CLIP_EN
        if (px < 0 || px >= 640 || py < 0 || py >= 480)
          continue;
`endif
        exp_q.push_back({10'(px & 1023), 10'(py & 1023)});
      end
      cyo++;
      if (dd < 0) dd += 2 * cyo + 1;
      else begin
        cxo--;
        dd += 2 * (cyo - cxo) + 1;
      end
    end while (cyo <= cxo);
  endtask

  task automatic run(input int i, input int mode,
                     input int rst_at, input int exp_cnt);
    int n, total, cyc;
    int pat [4] = '{1, 0, 0, 1};
    bit r, stall;
    logic [9:0] hx, hy;
    logic [19:0] e;
    build(i);
    total = exp_q.size();
    n = 0;
    cyc = 0;
    stall = 1'b0;
    hx = '0;
    hy = '0;
    @(negedge clk);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
    chk("busy_on", 32'(busy_s[i]), 1);
    while (n < total && n != rst_at && cyc < 3000) begin
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: r = 1'(pat[cyc % 4]);
      endcase
      ready_s[i] = r;
      if (stall) begin
        chk("hold_x", 32'(xs[i]), 32'(hx));
        chk("hold_y", 32'(ys[i]), 32'(hy));
      end
      if (valid_s[i]) begin
        if (r) begin
          e = exp_q[n];
          chk("pt_x", 32'(xs[i]), 32'(e[19:10]));
          chk("pt_y", 32'(ys[i]), 32'(e[9:0]));
          if (i == 0 && n == 0) begin
            chk("first_x", 32'(xs[i]), 15);
            chk("first_y", 32'(ys[i]), 10);
          end
`ifdef CIRCLE_CLIP_EN
          if (i == 2) chk("clip_x", 32'(xs[i] < 10'd640), 1);
`else
          if (i == 2 && n == 1) chk("oct1_wrap", 32'(xs[i]), 1021);
`endif
          n++;
        end
        stall = !r;
        hx = xs[i];
        hy = ys[i];
      end else begin
        stall = 1'b0;
      end
      start_s[i] = (mode == 1 && n > 0 && n < total - 1
                    && $urandom_range(0, 7) == 0);
      cyc++;
      @(negedge clk);
    end
    start_s[i] = 1'b0;
    ready_s[i] = 1'b0;
    if (cyc >= 3000) begin
      chk("timeout", 0, 1);
    end else if (n == rst_at) begin
      reset = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(valid_s[i]), 0);
      chk("rst_busy", 32'(busy_s[i]), 0);
      reset = 1'b0;
    end else begin
      chk("done_early", 32'(done_s[i]), 0);
      @(negedge clk);
      chk("done_pulse", 32'(done_s[i]), 1);
      chk("done_busy", 32'(busy_s[i]), 1);
      @(negedge clk);
      chk("done_clear", 32'(done_s[i]), 0);
      chk("busy_off", 32'(busy_s[i]), 0);
      if (exp_cnt >= 0) chk("xfer_count", n, exp_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      ready_s[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_valid0", 32'(valid_s[0]), 0);
    chk("rst_busy0", 32'(busy_s[0]), 0);
    chk("rst_done0", 32'(done_s[0]), 0);
    chk("rst_x0", 32'(xs[0]), 0);
    chk("rst_y0", 32'(ys[0]), 0);
    reset = 1'b0;
    run(0, 0, -1, 32);
    run(1, 0, -1, 8);
    run(0, 2, -1, 32);
    run(0, 0, 10, -1);
    run(0, 0, -1, 32);
    run(0, 1, -1, 32);
    run(1, 1, -1, 8);
`ifdef CIRCLE_CLIP_EN
    run(2, 1, -1, -1);
`else
    run(2, 1, -1, 32);
`endif
    run(0, 1, -1, 32);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
